// File: rtl/alu6_seq.sv
// alu6_seq: command sequencer in front of the 6-bit serial-load ALU wrapper (alu6).
// Accepts {f, a, b} on a valid/ready command port, streams a, b and f into alu6
// over three cycles using the en/sel/x load protocol, waits one cycle for alu6 to
// register its result, then captures {y, z} and presents it on a valid/ready
// result port together with an illegal-opcode flag.
//
// Ports
//   clk, rstn            system clock; synchronous active-low reset
//   in_valid/in_ready    command handshake (in_ready high only in IDLE)
//   in_f/in_a/in_b       command opcode and operands
//   out_valid/out_ready  result handshake
//   out_y/out_z/out_err  captured result, zero flag, opcode > MAX_OP
//   busy                 high whenever a command is in flight or a result is pending
//   alu_en/alu_sel/alu_x load protocol towards alu6
//   alu_y/alu_z          registered result from alu6
//
// FSM states
//   state | meaning
//   IDLE  | waiting for a command; in_ready=1
//   LD_A  | load operand a into alu6 (sel=00)
//   LD_B  | load operand b into alu6 (sel=01)
//   LD_F  | load opcode f into alu6 (sel=10)
//   EXEC  | alu6 registers its result at this edge
//   CAPT  | capture alu6 result into the output registers
//   DONE  | result valid, waiting for out_ready

module alu6_seq #(
  parameter int             WIDTH  = 6,
  parameter int             OPW    = 3,
  parameter logic [OPW-1:0] MAX_OP = 3'b100
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   in_f,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_z,
  output logic             out_err,
  output logic             busy,
  output logic             alu_en,
  output logic [1:0]       alu_sel,
  output logic [WIDTH-1:0] alu_x,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_z
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LD_A = 3'd1,
    LD_B = 3'd2,
    LD_F = 3'd3,
    EXEC = 3'd4,
    CAPT = 3'd5,
    DONE = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [OPW-1:0]   f_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_y_q;
  logic             out_z_q;
  logic             out_err_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      f_q         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
      out_z_q     <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && in_valid) begin
        f_q <= in_f;
        a_q <= in_a;
        b_q <= in_b;
      end
      // alu_y/alu_z are only looked at on the CAPT edge; the result registers
      // otherwise hold their value, including after the result handshake.
      if (state_q == CAPT) begin
        out_y_q     <= alu_y;
        out_z_q     <= alu_z;
        out_err_q   <= (f_q > MAX_OP);
        out_valid_q <= 1'b1;
      end else if (state_q == DONE && out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    alu_en  = 1'b0;
    alu_sel = 2'b11;
    alu_x   = '0;
    unique case (state_q)
      IDLE: if (in_valid) state_d = LD_A;
      LD_A: begin
        alu_en  = 1'b1;
        alu_sel = 2'b00;
        alu_x   = a_q;
        state_d = LD_B;
      end
      LD_B: begin
        alu_en  = 1'b1;
        alu_sel = 2'b01;
        alu_x   = b_q;
        state_d = LD_F;
      end
      LD_F: begin
        alu_en  = 1'b1;
        alu_sel = 2'b10;
        alu_x   = {{(WIDTH-OPW){1'b0}}, f_q};
        state_d = EXEC;
      end
      EXEC: state_d = CAPT;
      CAPT: state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_y     = out_y_q;
  assign out_z     = out_z_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_alu6_seq.sv
// Bench for alu6_seq: directed scenarios plus a randomized command stream.
// Commands are pushed into a scoreboard at acceptance with the expected result
// from a plain arithmetic reference; a negedge monitor checks the load sequence,
// latency and result of the command at the head of the scoreboard.

module tb_alu6_seq;

  logic       clk = 1'b0;
  logic       rstn;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_f;
  logic [5:0] in_a, in_b;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] out_y;
  logic       out_z, out_err, busy;
  logic       alu_en;
  logic [1:0] alu_sel;
  logic [5:0] alu_x;
  logic [5:0] alu_y;
  logic       alu_z;

  always #5 clk = ~clk;

  alu6_seq #(.WIDTH(6), .OPW(3), .MAX_OP(3'b100)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_f(in_f), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_z(out_z), .out_err(out_err),
    .busy(busy),
    .alu_en(alu_en), .alu_sel(alu_sel), .alu_x(alu_x),
    .alu_y(alu_y), .alu_z(alu_z)
  );

  // Reference: {z, y} for one operation.
  function automatic logic [6:0] ref_res(input logic [2:0] f, input logic [5:0] a, input logic [5:0] b);
    logic [5:0] y;
    case (f)
      3'd0: y = a + b;
      3'd1: y = a - b;
      3'd2: y = a & b;
      3'd3: y = a | b;
      3'd4: y = a ^ b;
      default: y = 6'd0;
    endcase
    return {(y == 6'd0), y};
  endfunction

  // alu6 wrapper model: serial-load registers, registered result, no reset.
  logic [5:0] m_a = '0, m_b = '0;
  logic [2:0] m_f = '0;
  always @(posedge clk) begin
    if (alu_en) begin
      case (alu_sel)
        2'b00: m_a <= alu_x;
        2'b01: m_b <= alu_x;
        2'b10: m_f <= alu_x[2:0];
        default: ;
      endcase
    end
    {alu_z, alu_y} <= ref_res(m_f, m_a, m_b);
  end

  typedef struct {
    logic [2:0] f;
    logic [5:0] a, b, y;
    logic       z, err;
    int         acc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0, errors = 0;
  int   cyc = 0;
  int   n_acc = 0;
  int   last_acc = -1000;
  int   hs_edge = -1000;
  bit   b2b_chk = 0;
  logic [5:0] last_y = '0;
  logic       last_z = 1'b0, last_err = 1'b0;
  int   d_mon;

  bit   bp_rand = 0;
  logic dir_ready = 1'b1;
  logic rnd_ready = 1'b1;
  assign out_ready = bp_rand ? rnd_ready : dir_ready;

  always @(posedge clk) cyc <= cyc + 1;

  always begin
    @(posedge clk);
    #1;
    if (bp_rand) rnd_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor/scoreboard
  always @(negedge clk) begin
    if (!rstn) begin
      sb.delete();
      last_y   = '0;
      last_z   = 1'b0;
      last_err = 1'b0;
    end else begin
      chk("in_ready_vs_busy", int'(in_ready), int'(!busy));
      if (in_valid && in_ready) begin
        exp_t e;
        logic [6:0] r;
        r     = ref_res(in_f, in_a, in_b);
        e.f   = in_f;
        e.a   = in_a;
        e.b   = in_b;
        e.y   = r[5:0];
        e.z   = r[6];
        e.err = (in_f > 3'd4);
        e.acc = cyc + 1;
        if (b2b_chk) chk("accept_spacing", e.acc - last_acc, 7);
        last_acc = e.acc;
        n_acc++;
        sb.push_back(e);
      end
      if (sb.size() > 0 && cyc >= sb[0].acc) begin
        d_mon = cyc - sb[0].acc;
        case (d_mon)
          0: begin
            chk("lda_en", int'(alu_en), 1);
            chk("lda_sel", int'(alu_sel), 0);
            chk("lda_x", int'(alu_x), int'(sb[0].a));
          end
          1: begin
            chk("ldb_en", int'(alu_en), 1);
            chk("ldb_sel", int'(alu_sel), 1);
            chk("ldb_x", int'(alu_x), int'(sb[0].b));
          end
          2: begin
            chk("ldf_en", int'(alu_en), 1);
            chk("ldf_sel", int'(alu_sel), 2);
            chk("ldf_x", int'(alu_x), int'(sb[0].f));
          end
          3, 4: begin
            chk("exec_en", int'(alu_en), 0);
            chk("early_valid", int'(out_valid), 0);
          end
          default: begin
            chk("out_valid", int'(out_valid), 1);
            chk("out_y", int'(out_y), int'(sb[0].y));
            chk("out_z", int'(out_z), int'(sb[0].z));
            chk("out_err", int'(out_err), int'(sb[0].err));
            chk("done_in_ready", int'(in_ready), 0);
            if (out_valid && out_ready) begin
              hs_edge  = cyc + 1;
              last_y   = sb[0].y;
              last_z   = sb[0].z;
              last_err = sb[0].err;
              void'(sb.pop_front());
            end
          end
        endcase
      end else if (sb.size() == 0) begin
        chk("spurious_valid", int'(out_valid), 0);
        chk("hold_y", int'(out_y), int'(last_y));
        chk("hold_z", int'(out_z), int'(last_z));
        chk("hold_err", int'(out_err), int'(last_err));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [2:0] f, input logic [5:0] a, input logic [5:0] b, input bit hold);
    int n;
    n = 0;
    in_f = f; in_a = a; in_b = b; in_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 100);
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready never rose for f=%0d a=%0h b=%0h", f, a, b);
    end
    @(posedge clk);
    #1;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((sb.size() != 0 || busy) && n < 200);
    if (sb.size() != 0 || busy) begin
      checks++; errors++;
      $display("FAIL drain_timeout: pending=%0d busy=%0b", sb.size(), busy);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, n;
    rstn = 1'b0; in_valid = 1'b0; in_f = '0; in_a = '0; in_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_y", int'(out_y), 0);
    chk("rst_alu_en", int'(alu_en), 0);
    chk("rst_alu_sel", int'(alu_sel), 3);
    chk("rst_alu_x", int'(alu_x), 0);
    @(posedge clk); #1;
    rstn = 1'b1;

    // Directed operations
    send(3'b000, 6'd5, 6'd3, 0);        drain();
    send(3'b001, 6'd3, 6'd5, 0);        drain();
    send(3'b100, 6'h2A, 6'h2A, 0);      drain();
    send(3'b110, 6'd7, 6'd1, 0);        drain();
    send(3'b011, 6'h30, 6'h03, 0);      drain();

    // Backpressure in DONE, with an ignored command pulse
    dir_ready = 1'b0;
    send(3'b000, 6'd20, 6'd9, 0);
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 50);
    chk("bp_valid_rise", int'(out_valid), 1);
    @(posedge clk); #1;
    n0 = n_acc;
    repeat (4) begin
      in_f = 3'b010; in_a = 6'h3F; in_b = 6'h15; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    chk("bp_no_accept", n_acc, n0);
    dir_ready = 1'b1;
    send(3'b001, 6'd1, 6'd2, 0);
    chk("bp_idle_gap", last_acc - hs_edge, 1);
    drain();

    // Reset in the middle of a command
    send(3'b000, 6'd9, 6'd9, 0);
    @(posedge clk); #1;
    rstn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_alu_en", int'(alu_en), 0);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_out_y", int'(out_y), 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    send(3'b000, 6'd1, 6'd1, 0);        drain();

    // Back-to-back with in_valid held high
    send(3'b000, 6'd10, 6'd4, 1);
    b2b_chk = 1;
    send(3'b001, 6'd10, 6'd4, 1);
    send(3'b010, 6'd10, 6'd4, 0);
    drain();
    b2b_chk = 0;

    // Randomized stream with random result backpressure
    bp_rand = 1;
    repeat (40) begin
      send(3'($urandom_range(0, 7)), 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), 0);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    bp_rand = 0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
